fifo_wr_ctrl: RTL and testbench

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/cdc_sync.sv | 35 +++
 rtl/fifo_wr_ctrl.sv | 108 ++++++++++
 tb/tb_fifo_wr_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared FIFO helpers: Gray/binary pointer conversion and the
//                depth derivation used by both write and read controllers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Widest pointer the helpers handle; callers zero-extend and truncate.
  localparam int c_PTR_MAX_W = 32;

  // FIFO depth for a given address width.
  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // Binary to reflected Gray code.
  function automatic logic [c_PTR_MAX_W-1:0] bin2gray(input logic [c_PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reflected Gray code to binary (prefix XOR from the MSB down).
  function automatic logic [c_PTR_MAX_W-1:0] gray2bin(input logic [c_PTR_MAX_W-1:0] g);
    logic [c_PTR_MAX_W-1:0] b;
    b[c_PTR_MAX_W-1] = g[c_PTR_MAX_W-1];
    for (int i = c_PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/cdc_sync.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_sync
//  Description : Two-flop bus synchronizer. Only safe for buses where at most
//                one bit changes per source clock (e.g. Gray pointers).
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_sync #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // The input feeds the first stage directly; no logic in front of it.
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_meta;
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_sync;

  // Two back-to-back capture stages to resolve metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule : cdc_sync
`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_ctrl
//  Description : Write-side controller of an async FIFO. Keeps the binary and
//                Gray write pointers, synchronizes the read Gray pointer and
//                produces registered full / almost_full / level flags plus a
//                sticky overflow indicator.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int AW        = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW:0]   rd_gray_async,
  output logic          wr_accept,
  output logic [AW-1:0] wr_addr,
  output logic [AW:0]   wr_gray,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   wr_level,
  output logic          overflow
);

  localparam int             c_PTR_W     = AW + 1;
  localparam int             c_LVL_W     = AW + 2;
  localparam logic [AW+1:0]  c_DEPTH     = c_LVL_W'(fifo_depth(AW));
  localparam logic [AW+1:0]  c_AF_MARGIN = c_LVL_W'(AF_MARGIN);

  // Registered state
  logic [AW:0] r_wr_bin;
  logic [AW:0] r_wr_gray;
  logic        r_full;
  logic        r_almost_full;
  logic [AW:0] r_level;
  logic        r_overflow;

  // Combinational next-state
  logic          w_accept;
  logic [AW:0]   w_wr_bin_next;
  logic [AW:0]   w_wr_gray_next;
  logic [AW:0]   w_rd_gray_s;
  logic [AW:0]   w_rd_bin_s;
  logic [AW:0]   w_level_next;
  logic [AW+1:0] w_free_next;
  logic          w_full_next;
  logic          w_almost_full_next;

  cdc_sync #(
    .WIDTH (c_PTR_W)
  ) u_rd_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rd_gray_async),
    .o_q (w_rd_gray_s)
  );

  // Next pointer and flag values; a write and a read advance seen in the same
  // cycle are both folded into one level computation.
  always_comb begin
    w_accept           = wr_en & ~r_full & ~rst;
    w_wr_bin_next      = r_wr_bin + {{AW{1'b0}}, w_accept};
    w_wr_gray_next     = c_PTR_W'(bin2gray(32'(w_wr_bin_next)));
    w_rd_bin_s         = c_PTR_W'(gray2bin(32'(w_rd_gray_s)));
    w_level_next       = w_wr_bin_next - w_rd_bin_s;
    w_free_next        = c_DEPTH - {1'b0, w_level_next};
    // Full when the write pointer is exactly one lap ahead of the read pointer;
    // in Gray code that is the top two bits inverted, the rest equal.
    w_full_next        = (w_wr_gray_next ==
                          {~w_rd_gray_s[AW:AW-1], w_rd_gray_s[AW-2:0]});
    w_almost_full_next = (w_free_next <= c_AF_MARGIN);
  end

  // All write-domain state; overflow is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bin      <= '0;
      r_wr_gray     <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_level       <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_wr_bin      <= w_wr_bin_next;
      r_wr_gray     <= w_wr_gray_next;
      r_full        <= w_full_next;
      r_almost_full <= w_almost_full_next;
      r_level       <= w_level_next;
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign wr_accept   = w_accept;
  assign wr_addr     = r_wr_bin[AW-1:0];
  assign wr_gray     = r_wr_gray;
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign wr_level    = r_level;
  assign overflow    = r_overflow;

endmodule : fifo_wr_ctrl
`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_ctrl
//  Description : Self-checking bench for fifo_wr_ctrl (AW=4, AF_MARGIN=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_ctrl;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW:0]   rd_gray_async;
  logic          wr_accept;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_gray;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_level;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_wr_ctrl #(
    .AW        (4),
    .AF_MARGIN (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .rd_gray_async (rd_gray_async),
    .wr_accept     (wr_accept),
    .wr_addr       (wr_addr),
    .wr_gray       (wr_gray),
    .full          (full),
    .almost_full   (almost_full),
    .wr_level      (wr_level),
    .overflow      (overflow)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] m5, rd_now, s1, s2, lvl, prev_gray;
    logic       mf, maf, movf, acc, we;
    int         m;

    rst = 1'b1; wr_en = 1'b0; rd_gray_async = '0;
    tick(); tick();
    // Reset state
    check_val("rst_level",   32'(wr_level),    0);
    check_val("rst_full",    32'(full),        0);
    check_val("rst_afull",   32'(almost_full), 0);
    check_val("rst_ovf",     32'(overflow),    0);
    check_val("rst_gray",    32'(wr_gray),     0);
    check_val("rst_addr",    32'(wr_addr),     0);
    wr_en = 1'b1; #1;
    check_val("rst_accept",  32'(wr_accept),   0);
    wr_en = 1'b0;
    rst = 1'b0;
    tick();

    // 16 back-to-back writes, read pointer parked at 0
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; #1;
      check_val("fill_addr",   32'(wr_addr),   32'(i));
      check_val("fill_accept", 32'(wr_accept), 1);
      tick();
      check_val("fill_level",  32'(wr_level),    32'(i + 1));
      check_val("fill_afull",  32'(almost_full), 32'((i + 1) >= 14));
      check_val("fill_full",   32'(full),        32'((i + 1) == 16));
    end

    // Writes while full are refused and set overflow
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; #1;
      check_val("ovf_accept", 32'(wr_accept), 0);
      tick();
      check_val("ovf_addr",   32'(wr_addr),   0);
      check_val("ovf_gray",   32'(wr_gray),   32'(5'b11000));
      check_val("ovf_flag",   32'(overflow),  1);
      check_val("ovf_level",  32'(wr_level),  16);
    end
    wr_en = 1'b0;

    // Read pointer Gray(0)->Gray(1): full clears exactly 3 edges later
    rd_gray_async = 5'b00001;
    tick();
    check_val("rd1_full_e1", 32'(full), 1);
    tick();
    check_val("rd1_full_e2", 32'(full), 1);
    tick();
    check_val("rd1_full_e3",  32'(full),        0);
    check_val("rd1_level",    32'(wr_level),    15);
    check_val("rd1_afull",    32'(almost_full), 1);
    check_val("ovf_sticky",   32'(overflow),    1);

    // Reset, then run writes with the reader 4 entries behind across wrap
    rst = 1'b1; rd_gray_async = '0; tick();
    check_val("rst2_ovf", 32'(overflow), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; tick();
    end
    check_val("track_start", 32'(wr_level), 4);
    m = 4;
    for (int j = 0; j < 40; j++) begin
      wr_en = 1'b1;
      rd_gray_async = gray5(5'(m - 4));
      #1;
      check_val("track_addr", 32'(wr_addr), 32'(m % 16));
      tick();
      m++;
      if (j >= 2) check_val("track_level", 32'(wr_level), 7);
      check_val("track_full", 32'(full), 0);
    end
    check_val("track_wrap_gray", 32'(wr_gray), 32'(gray5(5'(m))));
    wr_en = 1'b0;

    // Reset mid-operation at level 9 with wr_en held
    rst = 1'b1; rd_gray_async = '0; tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; tick();
    end
    check_val("pre_rst_level", 32'(wr_level), 9);
    rst = 1'b1; wr_en = 1'b1; #1;
    check_val("midrst_accept", 32'(wr_accept), 0);
    tick();
    check_val("midrst_level", 32'(wr_level),    0);
    check_val("midrst_addr",  32'(wr_addr),     0);
    check_val("midrst_gray",  32'(wr_gray),     0);
    check_val("midrst_full",  32'(full),        0);
    check_val("midrst_afull", 32'(almost_full), 0);
    check_val("midrst_ovf",   32'(overflow),    0);
    rst = 1'b0; wr_en = 1'b0;

    // Random writes against a lagged read-pointer model
    m5 = '0; rd_now = '0; s1 = '0; s2 = '0; mf = 1'b0; movf = 1'b0;
    prev_gray = '0;
    for (int k = 0; k < 300; k++) begin
      we = ($urandom_range(0, 3) != 0);
      if (rd_now != m5 && $urandom_range(0, 2) == 0) rd_now = rd_now + 5'd1;
      wr_en = we;
      rd_gray_async = gray5(rd_now);
      #1;
      acc = we & ~mf;
      check_val("rnd_accept", 32'(wr_accept), 32'(acc));
      tick();
      movf = movf | (we & mf);
      m5   = m5 + {4'd0, acc};
      lvl  = m5 - s2;
      mf   = (lvl == 5'd16);
      maf  = (16 - int'(lvl)) <= 2;
      s2   = s1;
      s1   = rd_now;
      check_val("rnd_level", 32'(wr_level),    32'(lvl));
      check_val("rnd_full",  32'(full),        32'(mf));
      check_val("rnd_afull", 32'(almost_full), 32'(maf));
      check_val("rnd_ovf",   32'(overflow),    32'(movf));
      check_val("rnd_gray",  32'(wr_gray),     32'(gray5(m5)));
      check_val("rnd_gray_step", 32'($countones(prev_gray ^ wr_gray) <= 1), 1);
      if (5'(m5 - rd_now) == 5'd16) check_val("rnd_never_late", 32'(full), 1);
      prev_gray = wr_gray;
    end
    wr_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo_wr_ctrl
`default_nettype wire
